// File: rtl/lsu_mem_master.sv
// RV32I load/store initiator: one request in, one single-cycle memory access, one response out.
// Optional LSU_MISALIGN_TRAP_EN makes misaligned halfword/word accesses fault instead of issuing.
module lsu_mem_master #(
  parameter int ADDR_W    = 32,
  parameter int MEM_BYTES = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_is_store,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_write_data,
  output logic [3:0]        mem_byte_enable,
  input  logic [31:0]       mem_data_in
);

  // state  | meaning
  // IDLE   | ready for a request
  // ACCESS | single cycle with the memory strobe driven
  // RESP   | response held until the pipeline takes it
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam int AW1 = ADDR_W + 1;

  state_t state, state_next;

  logic              is_store_q;
  logic [2:0]        funct3_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic              err_q;
  logic [31:0]       rdata_q;

  logic [2:0]   req_size;
  logic [AW1-1:0] req_last;
  logic         req_illegal;
  logic         req_out_of_range;
  logic         req_misaligned;
  logic         req_err;
  logic [3:0]   be_full;
  logic [31:0]  byte_mask;
  logic [31:0]  load_fmt;

  always_comb begin
    case (req_funct3[1:0])
      2'b00:   req_size = 3'd1;
      2'b01:   req_size = 3'd2;
      default: req_size = 3'd4;
    endcase
  end

  assign req_illegal = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11) ||
                       (req_is_store && req_funct3[2]);

  // One extra bit so addresses near the top of the space cannot wrap past the limit.
  assign req_last         = {1'b0, req_addr} + AW1'(req_size) - AW1'(1);
  assign req_out_of_range = (req_last >= AW1'(MEM_BYTES));

`ifdef LSU_MISALIGN_TRAP_EN
  assign req_misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                          ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
`else
  assign req_misaligned = 1'b0;
`endif

  assign req_err = req_illegal || req_out_of_range || req_misaligned;

  always_comb begin
    case (funct3_q[1:0])
      2'b00:   be_full = 4'b0001;
      2'b01:   be_full = 4'b0011;
      default: be_full = 4'b1111;
    endcase
  end

  assign byte_mask = {{8{be_full[3]}}, {8{be_full[2]}}, {8{be_full[1]}}, {8{be_full[0]}}};

  always_comb begin
    case (funct3_q)
      3'b000:  load_fmt = {{24{mem_data_in[7]}}, mem_data_in[7:0]};
      3'b100:  load_fmt = {24'h0, mem_data_in[7:0]};
      3'b001:  load_fmt = {{16{mem_data_in[15]}}, mem_data_in[15:0]};
      3'b101:  load_fmt = {16'h0, mem_data_in[15:0]};
      default: load_fmt = mem_data_in;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      is_store_q <= 1'b0;
      funct3_q   <= 3'b000;
      addr_q     <= '0;
      wdata_q    <= 32'h0;
      err_q      <= 1'b0;
      rdata_q    <= 32'h0;
    end else begin
      if (state == IDLE && req_valid) begin
        is_store_q <= req_is_store;
        funct3_q   <= req_funct3;
        addr_q     <= req_addr;
        wdata_q    <= req_wdata;
        err_q      <= req_err;
      end
      if (state == ACCESS) begin
        rdata_q <= (err_q || is_store_q) ? 32'h0 : load_fmt;
      end
    end
  end

  always_comb begin
    state_next      = state;
    req_ready       = 1'b0;
    rsp_valid       = 1'b0;
    rsp_rdata       = 32'h0;
    rsp_err         = 1'b0;
    mem_read        = 1'b0;
    mem_write       = 1'b0;
    mem_addr        = '0;
    mem_write_data  = 32'h0;
    mem_byte_enable = 4'b0000;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_next = ACCESS;
      end
      ACCESS: begin
        state_next = RESP;
        mem_addr   = addr_q;
        if (!err_q) begin
          mem_read        = !is_store_q;
          mem_write       = is_store_q;
          mem_byte_enable = be_full;
          mem_write_data  = wdata_q & byte_mask;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        rsp_rdata = rdata_q;
        rsp_err   = err_q;
        if (rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_lsu_mem_master.sv
// Bench for lsu_mem_master: byte memory model, directed vector table, then random traffic
// checked against a shadow-memory reference model.
module tb_lsu_mem_master;
  localparam int MB = 1024;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_is_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic        mem_read, mem_write;
  logic [31:0] mem_addr, mem_write_data, mem_data_in;
  logic [3:0]  mem_byte_enable;

  logic [7:0] dmem   [MB] = '{default: 8'h00};
  logic [7:0] shadow [MB] = '{default: 8'h00};

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  lsu_mem_master #(.ADDR_W(32), .MEM_BYTES(MB)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_write_data(mem_write_data), .mem_byte_enable(mem_byte_enable),
    .mem_data_in(mem_data_in)
  );

  assign mem_data_in = {dmem[mem_addr[9:0] + 10'd3], dmem[mem_addr[9:0] + 10'd2],
                        dmem[mem_addr[9:0] + 10'd1], dmem[mem_addr[9:0]]};

  always @(posedge clk) begin
    if (mem_write) begin
      for (int k = 0; k < 4; k++)
        if (mem_byte_enable[k]) dmem[mem_addr[9:0] + 10'(k)] <= mem_write_data[8*k +: 8];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: RV32I access rules applied to a byte-array view of memory.
  task automatic model(input bit st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, output bit err, output logic [31:0] rd,
                       output logic [3:0] be);
    int size;
    longint last;
    logic [31:0] w;
    size = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    err  = (f3 == 3'b011) || (f3 >= 3'b110) || (st && f3 >= 3'b100);
    last = longint'(a) + size - 1;
    if (last >= MB) err = 1'b1;
`ifdef LSU_MISALIGN_TRAP_EN
    if (size == 2 && a[0]) err = 1'b1;
    if (size == 4 && a[1:0] != 2'b00) err = 1'b1;
`endif
    be = err ? 4'b0000 : (size == 1) ? 4'b0001 : (size == 2) ? 4'b0011 : 4'b1111;
    rd = 32'h0;
    w  = 32'h0;
    if (!err && st)
      for (int k = 0; k < size; k++) shadow[int'(a) + k] = wd[8*k +: 8];
    if (!err && !st) begin
      for (int k = 0; k < size; k++) w[8*k +: 8] = shadow[int'(a) + k];
      case (f3)
        3'b000:  rd = {{24{w[7]}}, w[7:0]};
        3'b001:  rd = {{16{w[15]}}, w[15:0]};
        default: rd = w;
      endcase
    end
  endtask

  task automatic txn(input bit st, input logic [2:0] f3, input logic [31:0] a,
                     input logic [31:0] wd, input int stall,
                     output logic [31:0] rd_act, output logic err_act,
                     output logic [31:0] rd_exp, output bit err_exp);
    logic [3:0]  be_exp;
    logic [31:0] mask;
    model(st, f3, a, wd, err_exp, rd_exp, be_exp);
    for (int k = 0; k < 4; k++) mask[8*k +: 8] = be_exp[k] ? 8'hFF : 8'h00;
    chk("req_ready_idle", 32'(req_ready), 32'd1);
    req_is_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
    req_valid = 1'b1; rsp_ready = 1'b0;
    @(posedge clk); #1 req_valid = 1'b0;
    @(negedge clk);
    chk("access_read", 32'(mem_read), 32'(!err_exp && !st));
    chk("access_write", 32'(mem_write), 32'(!err_exp && st));
    chk("access_be", 32'(mem_byte_enable), 32'(be_exp));
    chk("access_addr", mem_addr, a);
    if (!err_exp && st) chk("access_wdata", mem_write_data, wd & mask);
    chk("valid_in_access", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    chk("latency_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("resp_strobes", {30'd0, mem_read, mem_write}, 32'd0);
    rd_act  = rsp_rdata;
    err_act = rsp_err;
    for (int s = 0; s < stall; s++) begin
      req_valid = 1'b1;
      @(negedge clk);
      chk("stall_valid", 32'(rsp_valid), 32'd1);
      chk("stall_rdata", rsp_rdata, rd_act);
      chk("stall_err", 32'(rsp_err), 32'(err_act));
      chk("stall_req_ready", 32'(req_ready), 32'd0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1 rsp_ready = 1'b0;
    @(negedge clk);
    chk("post_hs_valid", 32'(rsp_valid), 32'd0);
    chk("post_hs_ready", 32'(req_ready), 32'd1);
  endtask

  typedef struct {
    bit          st;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] wd;
    int          stall;
    logic [31:0] rd;
    bit          err;
  } vec_t;

  vec_t tbl[$];
  logic [31:0] rd_act, rd_exp;
  logic        err_act;
  bit          err_exp;
  logic [31:0] lw13_rd;
  bit          lw13_err;

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_is_store = 1'b0; req_funct3 = 3'b000;
    req_addr = 32'h0; req_wdata = 32'h0; rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_strobes", {30'd0, mem_read, mem_write}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_write_data, 32'd0);
    chk("rst_mem_be", 32'(mem_byte_enable), 32'd0);
    rst = 1'b0;
    @(negedge clk);

`ifdef LSU_MISALIGN_TRAP_EN
    lw13_rd = 32'h0; lw13_err = 1'b1;
`else
    lw13_rd = 32'h0000_00DE; lw13_err = 1'b0;
`endif
    tbl.push_back('{1, 3'b010, 32'h10,  32'hDEADBEEF, 0, 32'h0,         0});
    tbl.push_back('{0, 3'b010, 32'h10,  32'h0,        0, 32'hDEADBEEF,  0});
    tbl.push_back('{1, 3'b000, 32'h21,  32'h000000F0, 0, 32'h0,         0});
    tbl.push_back('{0, 3'b000, 32'h21,  32'h0,        0, 32'hFFFFFFF0,  0});
    tbl.push_back('{0, 3'b100, 32'h21,  32'h0,        0, 32'h000000F0,  0});
    tbl.push_back('{1, 3'b010, 32'h30,  32'h11223344, 0, 32'h0,         0});
    tbl.push_back('{1, 3'b001, 32'h30,  32'hABCD8001, 1, 32'h0,         0});
    tbl.push_back('{0, 3'b001, 32'h30,  32'h0,        0, 32'hFFFF8001,  0});
    tbl.push_back('{0, 3'b101, 32'h30,  32'h0,        0, 32'h00008001,  0});
    tbl.push_back('{0, 3'b010, 32'h30,  32'h0,        0, 32'h11228001,  0});
    tbl.push_back('{0, 3'b010, 32'd1021, 32'h0,       0, 32'h0,         1});
    tbl.push_back('{0, 3'b011, 32'h10,  32'h0,        0, 32'h0,         1});
    tbl.push_back('{0, 3'b010, 32'h10,  32'h0,        5, 32'hDEADBEEF,  0});
    tbl.push_back('{1, 3'b100, 32'h10,  32'h12345678, 0, 32'h0,         1});
    tbl.push_back('{0, 3'b010, 32'h10,  32'h0,        0, 32'hDEADBEEF,  0});
    tbl.push_back('{0, 3'b010, 32'h13,  32'h0,        0, lw13_rd,       lw13_err});
    tbl.push_back('{0, 3'b000, 32'd1023, 32'h0,       0, 32'h0,         0});
    tbl.push_back('{0, 3'b001, 32'd1023, 32'h0,       0, 32'h0,         1});
    tbl.push_back('{0, 3'b010, 32'd1020, 32'h0,       0, 32'h0,         0});
    tbl.push_back('{1, 3'b110, 32'h40,  32'hFFFFFFFF, 0, 32'h0,         1});

    foreach (tbl[i]) begin
      txn(tbl[i].st, tbl[i].f3, tbl[i].a, tbl[i].wd, tbl[i].stall,
          rd_act, err_act, rd_exp, err_exp);
      chk($sformatf("vec%0d_rdata", i), rd_act, tbl[i].rd);
      chk($sformatf("vec%0d_err", i), 32'(err_act), 32'(tbl[i].err));
    end

    // Reset while a store is in ACCESS: strobe drops at once and nothing is written.
    req_is_store = 1'b1; req_funct3 = 3'b010; req_addr = 32'h40; req_wdata = 32'hAAAAAAAA;
    req_valid = 1'b1;
    @(posedge clk); #1 req_valid = 1'b0;
    @(negedge clk);
    chk("mid_access_write", 32'(mem_write), 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_access_write_drop", 32'(mem_write), 32'd0);
    chk("rst_access_idle", 32'(req_ready), 32'd1);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    txn(0, 3'b010, 32'h40, 32'h0, 0, rd_act, err_act, rd_exp, err_exp);
    chk("after_rst_no_write", rd_act, 32'h0);

    // Reset while the response is pending discards it.
    req_is_store = 1'b0; req_funct3 = 3'b010; req_addr = 32'h10; req_valid = 1'b1;
    @(posedge clk); #1 req_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("resp_pending", 32'(rsp_valid), 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_resp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_resp_rdata", rsp_rdata, 32'd0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 200; i++) begin
      bit st;
      logic [2:0] f3;
      logic [31:0] a;
      logic [2:0] f3_pool [8];
      f3_pool = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b010, 3'b011, 3'b110};
      st = 1'($urandom_range(0, 1));
      f3 = f3_pool[$urandom_range(0, 7)];
      a  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(1016, 1030))
                                       : 32'($urandom_range(0, 63));
      txn(st, f3, a, $urandom, $urandom_range(0, 2), rd_act, err_act, rd_exp, err_exp);
      chk("rand_rdata", rd_act, rd_exp);
      chk("rand_err", 32'(err_act), 32'(err_exp));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
